// File: rtl/packet_disassembler.sv
// packet_disassembler: rebuilds the HDMI data-island header (BCH4) and four subpackets
//   (BCH0..3) from the TERC4-decoded 9-bit pixel stream and re-checks their BCH parity.
// Latency: packet_valid fires 1 cycle after the last pixel (counter==31). There is no
//   backpressure because the island stream cannot stall. Outputs hold until the next packet_valid.
// Ports: clk_pixel, reset (sync, active-high), data_island_period, packet_data[8:0] in;
//   counter[4:0], header[23:0], sub[3:0] (56b each), packet_valid, packet_abort,
//   header_ecc_err, sub_ecc_err[3:0] out.
// Define PACKET_ECC_CHECK_EN to build the parity checkers; otherwise the error flags are tied to 0.
module packet_disassembler (
   input  logic        clk_pixel,
   input  logic        reset,
   input  logic        data_island_period,
   input  logic [8:0]  packet_data,
   output logic [4:0]  counter,
   output logic [23:0] header,
   output logic [55:0] sub [3:0],
   output logic        packet_valid,
   output logic        packet_abort,
   output logic        header_ecc_err,
   output logic [3:0]  sub_ecc_err
);

   logic [31:0] hdr_sr;
   logic [63:0] sub_sr [3:0];
   logic [31:0] hdr_full;
   logic [63:0] sub_full [3:0];
   logic        last_pixel;

   // Bits arrive LSB first, so new bits enter at the top. The *_full views include
   // the bits of the current pixel. This lets the final pixel complete the packet on the
   // same edge that raises packet_valid.
   always_comb begin
      hdr_full = {packet_data[0], hdr_sr[31:1]};
      for (int n = 0; n < 4; n++) begin
         sub_full[n] = {packet_data[n+5], packet_data[n+1], sub_sr[n][63:2]};
      end
   end

   assign last_pixel = data_island_period && (counter == 5'd31);

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         counter      <= '0;
         hdr_sr       <= '0;
         header       <= '0;
         packet_valid <= 1'b0;
         packet_abort <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            sub_sr[n] <= '0;
            sub[n]    <= '0;
         end
      end else begin
         packet_valid <= 1'b0;
         packet_abort <= 1'b0;
         if (data_island_period) begin
            counter <= counter + 5'd1;
            hdr_sr  <= hdr_full;
            for (int n = 0; n < 4; n++) begin
               sub_sr[n] <= sub_full[n];
            end
            if (last_pixel) begin
               header       <= hdr_full[23:0];
               packet_valid <= 1'b1;
               for (int n = 0; n < 4; n++) begin
                  sub[n] <= sub_full[n][55:0];
               end
            end
         end else begin
            // A nonzero counter here means the island ended mid-packet. The counter has
            // already wrapped to 0 after a complete packet, so completion never aborts.
            counter      <= '0;
            hdr_sr       <= '0;
            packet_abort <= (counter != 5'd0);
            for (int n = 0; n < 4; n++) begin
               sub_sr[n] <= '0;
            end
         end
      end
   end

`ifdef PACKET_ECC_CHECK_EN
   logic [7:0] hdr_ecc;
   logic [7:0] sub_ecc [3:0];
   logic       unused_bits;

   function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
      ecc_step = (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
   endfunction

   // The received parity bits are not folded into the ECC. Header data ends at
   // pixel 23, and the subpacket data ends at pixel 27.
   always_ff @(posedge clk_pixel) begin
      if (reset || !data_island_period || last_pixel) begin
         hdr_ecc <= '0;
         for (int n = 0; n < 4; n++) begin
            sub_ecc[n] <= '0;
         end
      end else begin
         if (counter < 5'd24) begin
            hdr_ecc <= ecc_step(hdr_ecc, packet_data[0]);
         end
         if (counter < 5'd28) begin
            for (int n = 0; n < 4; n++) begin
               sub_ecc[n] <= ecc_step(ecc_step(sub_ecc[n], packet_data[n+1]), packet_data[n+5]);
            end
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         header_ecc_err <= 1'b0;
         sub_ecc_err    <= '0;
      end else if (last_pixel) begin
         header_ecc_err <= (hdr_ecc != hdr_full[31:24]);
         for (int n = 0; n < 4; n++) begin
            sub_ecc_err[n] <= (sub_ecc[n] != sub_full[n][63:56]);
         end
      end
   end

   assign unused_bits = ^{hdr_sr[0], sub_sr[0][1:0], sub_sr[1][1:0], sub_sr[2][1:0], sub_sr[3][1:0]};
`else
   logic unused_bits;

   assign header_ecc_err = 1'b0;
   assign sub_ecc_err    = 4'b0000;
   // Without the checker, the parity bits are captured but never compared.
   assign unused_bits = ^{hdr_sr[0], hdr_full[31:24],
                          sub_sr[0][1:0], sub_sr[1][1:0], sub_sr[2][1:0], sub_sr[3][1:0],
                          sub_full[0][63:56], sub_full[1][63:56], sub_full[2][63:56], sub_full[3][63:56]};
`endif

endmodule

// File: tb/tb_packet_disassembler.sv
// tb_packet_disassembler: randomized packet stream against a bit-level reference of the
//   BCH blocks; checks completion, hold, abort and reset behaviour of packet_disassembler.
// Timing: inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_packet_disassembler;

`ifdef PACKET_ECC_CHECK_EN
   localparam bit ECC_ON = 1'b1;
`else
   localparam bit ECC_ON = 1'b0;
`endif

   logic        clk_pixel = 1'b0;
   logic        reset;
   logic        data_island_period;
   logic [8:0]  packet_data;
   logic [4:0]  counter;
   logic [23:0] header;
   logic [55:0] sub [3:0];
   logic        packet_valid;
   logic        packet_abort;
   logic        header_ecc_err;
   logic [3:0]  sub_ecc_err;

   always #5 clk_pixel = ~clk_pixel;

   packet_disassembler dut (
      .clk_pixel          (clk_pixel),
      .reset              (reset),
      .data_island_period (data_island_period),
      .packet_data        (packet_data),
      .counter            (counter),
      .header             (header),
      .sub                (sub),
      .packet_valid       (packet_valid),
      .packet_abort       (packet_abort),
      .header_ecc_err     (header_ecc_err),
      .sub_ecc_err        (sub_ecc_err)
   );

   int n_vec = 0;
   int n_bad = 0;
   int valid_cnt = 0;
   int abort_cnt = 0;

   // Transmit side: payload, then BCH blocks as placed on the wire (possibly corrupted).
   logic [23:0]  tx_hdr;
   logic [55:0]  tx_sub [4];
   logic [31:0]  tx_b4;
   logic [63:0]  tx_b [4];

   // Expected receiver outputs.
   logic [23:0]  exp_header;
   logic [223:0] exp_sub_cat;
   logic         exp_herr;
   logic [3:0]   exp_serr;
   logic [223:0] got_sub;

   assign got_sub = {sub[3], sub[2], sub[1], sub[0]};

   always @(negedge clk_pixel) begin
      if (packet_valid === 1'b1) valid_cnt++;
      if (packet_abort === 1'b1) abort_cnt++;
   end

   function automatic logic [7:0] ecc_of(input logic [63:0] d, input int nbits);
      logic [7:0] e;
      e = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         e = (e >> 1) ^ (((e[0] ^ d[i]) == 1'b1) ? 8'h83 : 8'h00);
      end
      return e;
   endfunction

   task automatic random_payload();
      logic [31:0] t32;
      logic [63:0] t64;
      t32 = $urandom;
      tx_hdr = t32[23:0];
      for (int k = 0; k < 4; k++) begin
         t64 = {$urandom, $urandom};
         tx_sub[k] = t64[55:0];
      end
   endtask

   task automatic encode();
      tx_b4 = {ecc_of({40'd0, tx_hdr}, 24), tx_hdr};
      for (int k = 0; k < 4; k++) begin
         tx_b[k] = {ecc_of({8'd0, tx_sub[k]}, 56), tx_sub[k]};
      end
   endtask

   // The receiver reports whatever data arrived and whether its parity is consistent.
   task automatic predict();
      exp_header  = tx_b4[23:0];
      exp_sub_cat = {tx_b[3][55:0], tx_b[2][55:0], tx_b[1][55:0], tx_b[0][55:0]};
      exp_herr    = ECC_ON & (ecc_of({32'd0, tx_b4}, 24) != tx_b4[31:24]);
      for (int k = 0; k < 4; k++) begin
         exp_serr[k] = ECC_ON & (ecc_of(tx_b[k], 56) != tx_b[k][63:56]);
      end
   endtask

   task automatic drive_cycles(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         data_island_period = 1'b1;
         packet_data[0] = tx_b4[c];
         for (int k = 0; k < 4; k++) begin
            packet_data[k+1] = tx_b[k][2*c];
            packet_data[k+5] = tx_b[k][2*c+1];
         end
         @(posedge clk_pixel); #1;
      end
   endtask

   task automatic idle(input int n);
      data_island_period = 1'b0;
      packet_data = '0;
      repeat (n) begin
         @(posedge clk_pixel); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      data_island_period = 1'b0;
      packet_data = '0;
      repeat (3) begin
         @(posedge clk_pixel); #1;
      end
      n_vec++; if (counter !== 5'd0) begin n_bad++; $display("FAIL reset.counter got %h exp 0", counter); end
      n_vec++; if (header !== 24'd0) begin n_bad++; $display("FAIL reset.header got %h exp 0", header); end
      n_vec++; if (got_sub !== 224'd0) begin n_bad++; $display("FAIL reset.sub got %h exp 0", got_sub); end
      n_vec++; if (packet_valid !== 1'b0) begin n_bad++; $display("FAIL reset.valid got %b exp 0", packet_valid); end
      n_vec++; if (packet_abort !== 1'b0) begin n_bad++; $display("FAIL reset.abort got %b exp 0", packet_abort); end
      n_vec++; if ({header_ecc_err, sub_ecc_err} !== 5'd0) begin n_bad++; $display("FAIL reset.err got %b exp 0", {header_ecc_err, sub_ecc_err}); end
      reset = 1'b0;
      @(posedge clk_pixel); #1;
   endtask

   task automatic test_zero_packet();
      tx_hdr = '0;
      for (int k = 0; k < 4; k++) tx_sub[k] = '0;
      encode();
      predict();
      valid_cnt = 0;
      drive_cycles(32);
      n_vec++; if (valid_cnt != 0) begin n_bad++; $display("FAIL zero.early_valid got %0d exp 0", valid_cnt); end
      n_vec++; if (packet_valid !== 1'b1) begin n_bad++; $display("FAIL zero.valid got %b exp 1", packet_valid); end
      n_vec++; if (counter !== 5'd0) begin n_bad++; $display("FAIL zero.counter got %0d exp 0", counter); end
      n_vec++; if (header !== exp_header) begin n_bad++; $display("FAIL zero.header got %h exp %h", header, exp_header); end
      n_vec++; if (got_sub !== exp_sub_cat) begin n_bad++; $display("FAIL zero.sub got %h exp %h", got_sub, exp_sub_cat); end
      n_vec++; if ({header_ecc_err, sub_ecc_err} !== {exp_herr, exp_serr}) begin n_bad++; $display("FAIL zero.err got %b exp %b", {header_ecc_err, sub_ecc_err}, {exp_herr, exp_serr}); end
      idle(1);
      n_vec++; if (packet_valid !== 1'b0) begin n_bad++; $display("FAIL zero.valid_pulse got %b exp 0", packet_valid); end
      n_vec++; if (packet_abort !== 1'b0) begin n_bad++; $display("FAIL zero.no_abort got %b exp 0", packet_abort); end
   endtask

   // Runs one packet already in tx_*; name identifies the scenario in failure lines.
   task automatic test_single(input string name, input int flip_blk, input int flip_bit);
      encode();
      if (flip_blk == 4) tx_b4[flip_bit] = ~tx_b4[flip_bit];
      else if (flip_blk >= 0) tx_b[flip_blk][flip_bit] = ~tx_b[flip_blk][flip_bit];
      predict();
      drive_cycles(32);
      n_vec++; if (packet_valid !== 1'b1) begin n_bad++; $display("FAIL %s.valid got %b exp 1", name, packet_valid); end
      n_vec++; if (header !== exp_header) begin n_bad++; $display("FAIL %s.header got %h exp %h", name, header, exp_header); end
      n_vec++; if (got_sub !== exp_sub_cat) begin n_bad++; $display("FAIL %s.sub got %h exp %h", name, got_sub, exp_sub_cat); end
      n_vec++; if (header_ecc_err !== exp_herr) begin n_bad++; $display("FAIL %s.hdr_err got %b exp %b", name, header_ecc_err, exp_herr); end
      n_vec++; if (sub_ecc_err !== exp_serr) begin n_bad++; $display("FAIL %s.sub_err got %b exp %b", name, sub_ecc_err, exp_serr); end
      idle(1);
   endtask

   task automatic test_errors();
      logic [31:0] t32;
      random_payload();
      tx_hdr = 24'h0D0284;
      test_single("loopback", -1, 0);
      n_vec++; if (header !== 24'h0D0284) begin n_bad++; $display("FAIL loopback.hdr_literal got %h exp 0d0284", header); end
      test_single("hdr_parity_flip", 4, 30);
      test_single("sub2_bit17_flip", 2, 17);
      t32 = $urandom;
      tx_hdr = t32[23:0];
      test_single("hdr_data_flip", 4, 5);
   endtask

   task automatic test_back_to_back();
      valid_cnt = 0;
      random_payload();
      encode();
      tx_b[1][40] = ~tx_b[1][40];
      predict();
      drive_cycles(32);
      n_vec++; if (packet_valid !== 1'b1) begin n_bad++; $display("FAIL b2b.a_valid got %b exp 1", packet_valid); end
      n_vec++; if (got_sub !== exp_sub_cat) begin n_bad++; $display("FAIL b2b.a_sub got %h exp %h", got_sub, exp_sub_cat); end
      n_vec++; if (sub_ecc_err !== exp_serr) begin n_bad++; $display("FAIL b2b.a_sub_err got %b exp %b", sub_ecc_err, exp_serr); end
      random_payload();
      encode();
      predict();
      drive_cycles(32);
      n_vec++; if (valid_cnt != 1) begin n_bad++; $display("FAIL b2b.pulse_count got %0d exp 1", valid_cnt); end
      n_vec++; if (packet_valid !== 1'b1) begin n_bad++; $display("FAIL b2b.b_valid got %b exp 1", packet_valid); end
      n_vec++; if (header !== exp_header) begin n_bad++; $display("FAIL b2b.b_header got %h exp %h", header, exp_header); end
      n_vec++; if (got_sub !== exp_sub_cat) begin n_bad++; $display("FAIL b2b.b_sub got %h exp %h", got_sub, exp_sub_cat); end
      n_vec++; if ({header_ecc_err, sub_ecc_err} !== {exp_herr, exp_serr}) begin n_bad++; $display("FAIL b2b.b_err got %b exp %b", {header_ecc_err, sub_ecc_err}, {exp_herr, exp_serr}); end
      idle(1);
      n_vec++; if (packet_valid !== 1'b0) begin n_bad++; $display("FAIL b2b.pulse_width got %b exp 0", packet_valid); end
   endtask

   // Outputs from the previous packet (still in exp_*) must survive the abort.
   task automatic test_abort();
      valid_cnt = 0;
      abort_cnt = 0;
      random_payload();
      encode();
      drive_cycles(12);
      n_vec++; if (counter !== 5'd12) begin n_bad++; $display("FAIL abort.counter got %0d exp 12", counter); end
      idle(3);
      n_vec++; if (abort_cnt != 1) begin n_bad++; $display("FAIL abort.pulses got %0d exp 1", abort_cnt); end
      n_vec++; if (valid_cnt != 0) begin n_bad++; $display("FAIL abort.valid got %0d exp 0", valid_cnt); end
      n_vec++; if (header !== exp_header) begin n_bad++; $display("FAIL abort.header_held got %h exp %h", header, exp_header); end
      n_vec++; if (got_sub !== exp_sub_cat) begin n_bad++; $display("FAIL abort.sub_held got %h exp %h", got_sub, exp_sub_cat); end
      n_vec++; if ({header_ecc_err, sub_ecc_err} !== {exp_herr, exp_serr}) begin n_bad++; $display("FAIL abort.err_held got %b exp %b", {header_ecc_err, sub_ecc_err}, {exp_herr, exp_serr}); end
   endtask

   task automatic test_reset_mid();
      random_payload();
      test_single("post_abort", -1, 0);
      valid_cnt = 0;
      abort_cnt = 0;
      random_payload();
      encode();
      drive_cycles(20);
      n_vec++; if (counter !== 5'd20) begin n_bad++; $display("FAIL rstmid.counter got %0d exp 20", counter); end
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk_pixel); #1;
      end
      reset = 1'b0;
      idle(3);
      n_vec++; if (valid_cnt != 0) begin n_bad++; $display("FAIL rstmid.valid got %0d exp 0", valid_cnt); end
      n_vec++; if (abort_cnt != 0) begin n_bad++; $display("FAIL rstmid.abort got %0d exp 0", abort_cnt); end
      n_vec++; if (header !== 24'd0) begin n_bad++; $display("FAIL rstmid.header got %h exp 0", header); end
      n_vec++; if (got_sub !== 224'd0) begin n_bad++; $display("FAIL rstmid.sub got %h exp 0", got_sub); end
      n_vec++; if ({header_ecc_err, sub_ecc_err} !== 5'd0) begin n_bad++; $display("FAIL rstmid.err got %b exp 0", {header_ecc_err, sub_ecc_err}); end
      n_vec++; if (counter !== 5'd0) begin n_bad++; $display("FAIL rstmid.counter_clr got %0d exp 0", counter); end
   endtask

   task automatic test_random();
      int r;
      int npkt;
      npkt = 24;
      valid_cnt = 0;
      for (int p = 0; p < npkt; p++) begin
         random_payload();
         encode();
         r = $urandom_range(0, 6);
         if (r == 2) begin
            r = $urandom_range(0, 31);
            tx_b4[r] = ~tx_b4[r];
         end else if (r >= 3) begin
            tx_b[r-3][$urandom_range(0, 63)] = ~tx_b[r-3][$urandom_range(0, 63)];
         end
         predict();
         drive_cycles(32);
         n_vec++; if (packet_valid !== 1'b1) begin n_bad++; $display("FAIL rand%0d.valid got %b exp 1", p, packet_valid); end
         n_vec++; if (header !== exp_header) begin n_bad++; $display("FAIL rand%0d.header got %h exp %h", p, header, exp_header); end
         n_vec++; if (got_sub !== exp_sub_cat) begin n_bad++; $display("FAIL rand%0d.sub got %h exp %h", p, got_sub, exp_sub_cat); end
         n_vec++; if ({header_ecc_err, sub_ecc_err} !== {exp_herr, exp_serr}) begin n_bad++; $display("FAIL rand%0d.err got %b exp %b", p, {header_ecc_err, sub_ecc_err}, {exp_herr, exp_serr}); end
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(1);
      n_vec++; if (valid_cnt != npkt) begin n_bad++; $display("FAIL rand.pulse_count got %0d exp %0d", valid_cnt, npkt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      data_island_period = 1'b0;
      packet_data = '0;
      test_reset();
      test_zero_packet();
      test_errors();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
